dmem_store_buffer: RTL and testbench

Data-memory responder on the MEM-stage side of the pipeline's data-memory interface (8-bit word address, 32-bit store data, read/write enables, 32-bit read data). Stores go into a small in-order store buffer; a single-write-port 256x32 data array takes them as its write port becomes free. The write port is shared with a higher-priority program/data loader. Loads return data combinationally within the requesting cycle, and are forwarded from the youngest matching buffered store when one exists.

---
 rtl/dmem_store_buffer.sv | 154 +++++++++++++++
 tb/tb_dmem_store_buffer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer.sv
// Data-memory responder: in-order store buffer draining into a 2^AW x DW
// array whose single write port is shared with a higher-priority loader.
// Loads read combinationally, forwarding from the youngest buffered store.
module dmem_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] data,
  input  logic          rden,
  input  logic          wren,
  output logic [DW-1:0] q,
  output logic          stall,
  output logic          overflow,
  output logic          empty,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data
);

  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned WORDS = 1 << AW;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];

  logic [DW-1:0] mem_q [WORDS];

  logic          full;
  logic          drain;
  logic          enq;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [PW-1:0] fwd_idx;

  // rden only qualifies the request; q is driven regardless of it
  logic unused_rden;
  assign unused_rden = rden;

  assign full     = (count_q == CW'(DEPTH));
  assign drain    = (count_q != CW'(0)) && !ld_we;
  assign enq      = wren && (!full || drain);
  assign stall    = full && ld_we;
  assign empty    = (count_q == CW'(0));
  assign overflow = ovf_q;

  // Next-state for pointers, occupancy, sticky overflow and entry payloads
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    addr_d  = addr_q;
    data_d  = data_q;

    if (drain) begin
      head_d = head_q + PW'(1);
    end
    if (enq) begin
      addr_d[tail_q] = address;
      data_d[tail_q] = data;
      tail_d         = tail_q + PW'(1);
    end
    if (wren && !enq) begin
      ovf_d = 1'b1;
    end
    case ({enq, drain})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy/overflow registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Entry storage; contents are meaningless outside the head..tail window
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  // Array write-port arbitration: loader first, otherwise drain the head entry
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (!rst) begin
      if (ld_we) begin
        mem_we    = 1'b1;
        mem_waddr = ld_addr;
        mem_wdata = ld_data;
      end else if (drain) begin
        mem_we    = 1'b1;
        mem_waddr = addr_q[head_q];
        mem_wdata = data_q[head_q];
      end
    end
  end

  // Data array; not reset so contents survive rst
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Forwarding: walk entries oldest to youngest from head so the youngest match wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[fwd_idx] == address)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  // Load data: forwarded store if any, else asynchronous array read
  always_comb begin
    q = fwd_hit ? fwd_data : mem_q[address];
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Scoreboard bench for dmem_store_buffer against a queue/array reference model.
module tb_dmem_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] address;
  logic [DW-1:0] data;
  logic          rden;
  logic          wren;
  logic [DW-1:0] q;
  logic          stall;
  logic          overflow;
  logic          empty;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  dmem_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .address(address), .data(data), .rden(rden),
    .wren(wren), .q(q), .stall(stall), .overflow(overflow), .empty(empty),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] q;
    logic          stall;
    logic          empty;
    logic          ovf;
    logic          chk_q;
    logic          chk;
  } exp_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  exp_t          sb[$];
  ent_t          mq[$];
  logic [DW-1:0] mem_m [1 << AW];
  logic          ovf_m = 1'b0;

  int vectors    = 0;
  int miscompares = 0;

  task automatic cmp(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: pops one expectation per cycle and compares mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          if (e.chk_q) cmp("q", q, e.q);
          cmp("stall", DW'(stall), DW'(e.stall));
          cmp("empty", DW'(empty), DW'(e.empty));
          cmp("overflow", DW'(overflow), DW'(e.ovf));
        end
      end
    end
  end

  // One cycle: drive inputs, push expected outputs, advance the reference model
  task automatic step(input logic r, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic rd, input logic lw,
                      input logic [AW-1:0] la, input logic [DW-1:0] ldd,
                      input logic chk);
    exp_t e;
    logic drained;
    @(posedge clk);
    #1;
    rst = r; wren = w; address = a; data = d; rden = rd;
    ld_we = lw; ld_addr = la; ld_data = ldd;

    e.q = mem_m[a];
    foreach (mq[i]) if (mq[i].a == a) e.q = mq[i].d;
    e.stall = (mq.size() == DEPTH) && lw;
    e.empty = (mq.size() == 0);
    e.ovf   = ovf_m;
    e.chk_q = rd;
    e.chk   = chk;
    sb.push_back(e);

    if (r) begin
      mq.delete();
      ovf_m = 1'b0;
    end else begin
      drained = 1'b0;
      if (lw) mem_m[la] = ldd;
      else if (mq.size() > 0) begin
        mem_m[mq[0].a] = mq[0].d;
        void'(mq.pop_front());
        drained = 1'b1;
      end
      if (w) begin
        if (mq.size() < DEPTH) mq.push_back('{a: a, d: d});
        else ovf_m = 1'b1;
      end
      if (drained && mq.size() > DEPTH) ovf_m = 1'bx;
    end
  endtask

  task automatic idle_read(input logic [AW-1:0] a);
    step(1'b0, 1'b0, a, '0, 1'b1, 1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; wren = 1'b0; rden = 1'b0; ld_we = 1'b0;
    address = '0; data = '0; ld_addr = '0; ld_data = '0;

    // Reset; state before the first edge is unknown so the first cycle is unchecked
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b1, 1'b1, 8'd7, 32'hDEAD, 1'b0, 1'b1, 8'd7, 32'hBEEF, 1'b1);

    // Loader fills the whole array so the model knows every word
    for (int i = 0; i < (1 << AW); i++)
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, AW'(i), $urandom, 1'b1);

    // Loader write then read back
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 8'd5, 32'hAAAA0000, 1'b1);
    idle_read(8'd5);

    // Store then forward next cycle, then read from array once drained
    step(1'b0, 1'b1, 8'd3, 32'h11111111, 1'b0, 1'b0, '0, '0, 1'b1);
    idle_read(8'd3);
    idle_read(8'd3);

    // Loader holds the port; buffer fills with same-address stores
    for (int i = 1; i <= 4; i++)
      step(1'b0, 1'b1, 8'd9, DW'(i), 1'b1, 1'b1, 8'd200, 32'h0000C8C8, 1'b1);
    step(1'b0, 1'b0, 8'd9, '0, 1'b1, 1'b1, 8'd200, 32'h0000C8C8, 1'b1);
    step(1'b0, 1'b1, 8'd9, 32'h5A5A5A5A, 1'b1, 1'b1, 8'd200, 32'h0000C8C8, 1'b1);
    step(1'b0, 1'b1, 8'd10, 32'h5, 1'b1, 1'b0, '0, '0, 1'b1);
    idle_read(8'd9);
    idle_read(8'd10);
    for (int i = 0; i < 6; i++) idle_read(AW'(8 + i));

    // Three buffered stores discarded by reset
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, AW'(20 + i), 32'hF00D0000 + DW'(i), 1'b0, 1'b1, 8'd201, 32'h1, 1'b1);
    step(1'b1, 1'b0, 8'd20, '0, 1'b1, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 4; i++) idle_read(AW'(20 + i));

    // Random traffic over a small address set to exercise forwarding and wrap
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 65),
           AW'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 99) < 35), AW'($urandom_range(0, 7)), $urandom, 1'b1);
    end

    // Let the buffer drain, then sweep the array against the model
    for (int i = 0; i < DEPTH + 1; i++) idle_read(AW'(i));
    for (int i = 0; i < (1 << AW); i++) idle_read(AW'(i));

    @(negedge clk);
    @(negedge clk);
    cmp("scoreboard_drained", DW'(sb.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
